// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle control FSM: states, opcode/funct
// values, ALU select codes and datapath mux codes.
package mips_ctrl_pkg;

  localparam int SEL_W = 4;
  localparam int OP_W  = 6;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_I_EXEC, S_I_WB, S_TRAP
  } state_t;

  // Tells the ALU select decoder where its operation comes from.
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_ITYPE} sel_class_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [SEL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath bundle: instruction fields and status in, ALU select
// and mux/enable strobes out. The control FSM uses the master side.
interface mips_multicycle_control_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0]  opcode;
  logic [OP_W-1:0]  funct;
  logic             zero;
  logic             mem_ready;
  logic [SEL_W-1:0] selectionLines;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             PCWrite;
  logic [1:0]       PCSource;
  logic             illegal_op;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output selectionLines, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, PCWrite, PCSource, illegal_op
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  selectionLines, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, PCWrite, PCSource, illegal_op
  );
endinterface

// File: rtl/alu_select_decode.sv
// Combinational ALU operation select: fixed ADD/SUB, or decoded from the
// latched funct (R-type) or opcode (I-type). Flags unknown R-type funct codes.
module alu_select_decode
  import mips_ctrl_pkg::*;
(
  input  sel_class_t       sel_class,
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  funct,
  output logic [SEL_W-1:0] sel,
  output logic             illegal
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    sel     = ALU_ADD;
    illegal = 1'b0;
    unique case (sel_class)
      CLS_SUB: sel = ALU_SUB;
      CLS_RTYPE: begin
        case (funct)
          FN_ADD:  sel = ALU_ADD;
          FN_SUB:  sel = ALU_SUB;
          FN_AND:  sel = ALU_AND;
          FN_OR:   sel = ALU_OR;
          FN_SLT:  sel = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      CLS_ITYPE: begin
        case (opcode)
          OP_ANDI: sel = ALU_AND;
          OP_ORI:  sel = ALU_OR;
          OP_SLTI: sel = ALU_SLT;
          default: sel = ALU_ADD;
        endcase
      end
      default: sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (fetch/decode/execute/memory/writeback).
// Define ILLEGAL_TRAP_EN to trap unknown opcodes/functs into a sticky TRAP state.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  mips_multicycle_control_if.master bus
);

  state_t          state, next_state;
  logic [OP_W-1:0] op_q, funct_q;
  sel_class_t      sel_class;
  logic            funct_illegal;

  // NOTE: sequential state uses non-blocking assignments only; the latched
  // instruction fields are reset too so decode never sees X after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q    <= bus.opcode;
        funct_q <= bus.funct;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:                       next_state = S_MEM_ADDR;
          OP_RTYPE:                           next_state = S_R_EXEC;
          OP_BEQ:                             next_state = S_BRANCH;
          OP_J:                               next_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  next_state = S_I_EXEC;
`ifdef ILLEGAL_TRAP_EN
          default:                            next_state = S_TRAP;
`else
          default:                            next_state = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  next_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (bus.mem_ready) next_state = S_MEM_WB;
      S_MEM_WB:    next_state = S_FETCH;
      S_MEM_WRITE: if (bus.mem_ready) next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_R_EXEC:    next_state = funct_illegal ? S_TRAP : S_R_WB;
      S_TRAP:      next_state = S_TRAP;
`else
      S_R_EXEC:    next_state = S_R_WB;
      S_TRAP:      next_state = S_FETCH;
`endif
      S_R_WB, S_BRANCH, S_JUMP, S_I_WB: next_state = S_FETCH;
      S_I_EXEC:    next_state = S_I_WB;
      default:     next_state = S_FETCH;
    endcase
  end

  // Writeback states keep the execute-state select so the ALU result is stable.
  always_comb begin
    unique case (state)
      S_R_EXEC, S_R_WB: sel_class = CLS_RTYPE;
      S_I_EXEC, S_I_WB: sel_class = CLS_ITYPE;
      S_BRANCH:         sel_class = CLS_SUB;
      default:          sel_class = CLS_ADD;
    endcase
  end

  alu_select_decode u_sel (
    .sel_class (sel_class),
    .opcode    (op_q),
    .funct     (funct_q),
    .sel       (bus.selectionLines),
    .illegal   (funct_illegal)
  );

  always_comb begin
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = SRCB_REGB;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSource = PCSRC_ALU;
    unique case (state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE:    bus.ALUSrcB = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_R_EXEC:    bus.ALUSrcA = 1'b1;
      S_R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        bus.PCSource = PCSRC_ALUOUT;
        bus.PCWrite  = bus.zero;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_I_WB:      bus.RegWrite = 1'b1;
      default:     ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!reset_n)                 illegal_q <= 1'b0;
    else if (next_state == S_TRAP) illegal_q <= 1'b1;
  end
  assign bus.illegal_op = illegal_q;
`else
  logic unused_funct_illegal;
  assign unused_funct_illegal = funct_illegal;
  assign bus.illegal_op       = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: a per-instruction reference
// model queues the expected control word for every cycle; a monitor compares.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] sel;
    logic       srca;
    logic [1:0] srcb;
    logic       iord, mr, mw, irw, rw, rdst, m2r, pcw;
    logic [1:0] pcs;
    logic       ill;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();
  mips_multicycle_control dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  ctrl_t exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // ---------------- reference model ----------------
  function automatic ctrl_t idle();
    ctrl_t c = '0;
    c.sel = 4'b0010;
    return c;
  endfunction

  function automatic ctrl_t fetch(input logic r);
    ctrl_t c = idle();
    c.mr = 1'b1; c.srcb = 2'd1; c.irw = r; c.pcw = r;
    return c;
  endfunction

  function automatic ctrl_t decode();
    ctrl_t c = idle(); c.srcb = 2'd3; return c;
  endfunction

  function automatic ctrl_t memaddr();
    ctrl_t c = idle(); c.srca = 1'b1; c.srcb = 2'd2; return c;
  endfunction

  function automatic ctrl_t memread();
    ctrl_t c = idle(); c.mr = 1'b1; c.iord = 1'b1; return c;
  endfunction

  function automatic ctrl_t memwb();
    ctrl_t c = idle(); c.rw = 1'b1; c.m2r = 1'b1; return c;
  endfunction

  function automatic ctrl_t memwrite();
    ctrl_t c = idle(); c.mw = 1'b1; c.iord = 1'b1; return c;
  endfunction

  function automatic ctrl_t rexec(input logic [3:0] s);
    ctrl_t c = idle(); c.srca = 1'b1; c.sel = s; return c;
  endfunction

  function automatic ctrl_t rwb(input logic [3:0] s);
    ctrl_t c = idle(); c.rw = 1'b1; c.rdst = 1'b1; c.sel = s; return c;
  endfunction

  function automatic ctrl_t branch(input logic z);
    ctrl_t c = idle();
    c.srca = 1'b1; c.sel = 4'b0110; c.pcs = 2'd1; c.pcw = z;
    return c;
  endfunction

  function automatic ctrl_t jump();
    ctrl_t c = idle(); c.pcw = 1'b1; c.pcs = 2'd2; return c;
  endfunction

  function automatic ctrl_t iexec(input logic [3:0] s);
    ctrl_t c = idle(); c.srca = 1'b1; c.srcb = 2'd2; c.sel = s; return c;
  endfunction

  function automatic ctrl_t iwb(input logic [3:0] s);
    ctrl_t c = idle(); c.rw = 1'b1; c.sel = s; return c;
  endfunction

  function automatic ctrl_t trap();
    ctrl_t c = idle(); c.ill = 1'b1; return c;
  endfunction

  function automatic bit r_legal(input logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  endfunction

  function automatic logic [3:0] r_sel(input logic [5:0] f);
    case (f)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2a:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [3:0] i_sel(input logic [5:0] op);
    case (op)
      6'h0c:   return 4'b0000;
      6'h0d:   return 4'b0001;
      6'h0a:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- stimulus ----------------
  // One clock cycle: drive inputs, queue what the outputs must be during it.
  task automatic cycle(input ctrl_t e, input string nm, input logic rdy, input logic z);
    bus.mem_ready = rdy;
    bus.zero      = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic trap_then_reset();
    for (int i = 0; i < 3; i++) cycle(trap(), "trap_hold", rbit(), rbit());
    reset_n = 1'b0;
    cycle(trap(), "trap_reset", rbit(), rbit());
    reset_n = 1'b1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input int stalls);
    for (int i = 0; i < stalls; i++) cycle(fetch(1'b0), "fetch_stall", 1'b0, rbit());
    cycle(fetch(1'b1), "fetch", 1'b1, rbit());
    bus.opcode = op;
    bus.funct  = fn;
    cycle(decode(), "decode", rbit(), rbit());
    // Scramble the live fields: later states must use the decode-time copy.
    bus.opcode = 6'($urandom);
    bus.funct  = 6'($urandom);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fstall, input int mstall, input logic z);
    fetch_decode(op, fn, fstall);
    case (op)
      6'h23: begin
        cycle(memaddr(), "mem_addr", rbit(), rbit());
        for (int i = 0; i < mstall; i++) cycle(memread(), "mem_read_stall", 1'b0, rbit());
        cycle(memread(), "mem_read", 1'b1, rbit());
        cycle(memwb(), "mem_wb", rbit(), rbit());
      end
      6'h2b: begin
        cycle(memaddr(), "mem_addr", rbit(), rbit());
        for (int i = 0; i < mstall; i++) cycle(memwrite(), "mem_write_stall", 1'b0, rbit());
        cycle(memwrite(), "mem_write", 1'b1, rbit());
      end
      6'h00: begin
        cycle(rexec(r_sel(fn)), "r_exec", rbit(), rbit());
        if (TRAP_EN && !r_legal(fn)) trap_then_reset();
        else cycle(rwb(r_sel(fn)), "r_wb", rbit(), rbit());
      end
      6'h04: cycle(branch(z), "branch", rbit(), z);
      6'h02: cycle(jump(), "jump", rbit(), rbit());
      6'h08, 6'h0c, 6'h0d, 6'h0a: begin
        cycle(iexec(i_sel(op)), "i_exec", rbit(), rbit());
        cycle(iwb(i_sel(op)), "i_wb", rbit(), rbit());
      end
      default: if (TRAP_EN) trap_then_reset();
    endcase
  endtask

  // sw whose write is abandoned by a reset pulse while waiting on memory.
  task automatic sw_with_reset();
    fetch_decode(6'h2b, 6'h00, 0);
    cycle(memaddr(), "mem_addr", rbit(), rbit());
    cycle(memwrite(), "mem_write_stall", 1'b0, rbit());
    reset_n = 1'b0;
    cycle(memwrite(), "mem_write_reset", 1'b0, rbit());
    reset_n = 1'b1;
    cycle(fetch(1'b0), "fetch_after_reset", 1'b0, rbit());
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h3f};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    bus.opcode    = '0;
    bus.funct     = '0;
    @(posedge clk);
    #1;
    cycle(fetch(1'b1), "reset", 1'b1, 1'b0);
    cycle(fetch(1'b1), "reset", 1'b1, 1'b0);
    reset_n = 1'b1;

    run_instr(6'h00, 6'h22, 0, 0, 1'b0);  // sub
    run_instr(6'h23, 6'h00, 0, 3, 1'b0);  // lw, 3 memory stalls
    run_instr(6'h04, 6'h00, 0, 0, 1'b1);  // beq taken
    run_instr(6'h04, 6'h00, 0, 0, 1'b0);  // beq not taken
    run_instr(6'h0a, 6'h00, 0, 0, 1'b0);  // slti
    run_instr(6'h0d, 6'h00, 0, 0, 1'b0);  // ori
    run_instr(6'h3f, 6'h00, 0, 0, 1'b0);  // unknown opcode
    sw_with_reset();
    run_instr(6'h00, 6'h3f, 1, 0, 1'b0);  // unknown funct

    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(0, 9)];
      if (op == 6'h3f) begin
        op = 6'($urandom);
        if (op_known(op)) op = 6'h3f;
      end
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- monitor ----------------
  initial begin
    ctrl_t act, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = '{sel: bus.selectionLines, srca: bus.ALUSrcA, srcb: bus.ALUSrcB,
                iord: bus.IorD, mr: bus.MemRead, mw: bus.MemWrite, irw: bus.IRWrite,
                rw: bus.RegWrite, rdst: bus.RegDst, m2r: bus.MemtoReg,
                pcw: bus.PCWrite, pcs: bus.PCSource, ill: bus.illegal_op};
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL %s @%0t: got %b required %b (sel|srcA|srcB|IorD|MR|MW|IRW|RW|RDst|M2R|PCW|PCSrc|ill)",
                   nm, $time, act, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
